// File: rtl/typing_judge.sv
// typing_judge: game-logic back end for the letter-typing game.
//
// Holds up to SLOTS falling letters. Each slot stores its letter, column and
// row. Letters fall one row per game tick, are cleared when their key is typed,
// and expire as misses when they fall past the bottom row. Hit and miss scores
// are kept as two-digit BCD counters that wrap 99 -> 00.
//
// Ports:
//   clk_50      in   system clock, all logic on the rising edge
//   rst         in   synchronous active-high reset, highest priority
//   tick        in   one-cycle pulse, advance every active letter one row
//   pause       in   level, freezes falling, matching and acceptance
//   gen_valid   in   one-cycle pulse, new letter offered by the generator
//   gen_ascii   in   offered letter (0x41..0x5A)
//   gen_x       in   offered column, stored unmodified
//   gen_ready   out  combinational: a slot is free and the game is not paused
//   key_valid   in   one-cycle pulse, decoded key
//   key_ascii   in   key code, lower case folded to upper case
//   slot_active out  per-slot occupied flag
//   slot_ascii  out  slot i letter at [8i+7:8i]
//   slot_x      out  slot i column at [6i+5:6i]
//   slot_y      out  slot i row at [5i+4:5i], row 0 is the top
//   hit_h/l     out  BCD hit count, tens/units
//   miss_h/l    out  BCD miss count, tens/units
//   hit_pulse   out  high for the cycle after a matching key
//   miss_pulse  out  high for the cycle after a tick that expired any letter

module typing_judge #(
    parameter int SLOTS = 4,
    parameter int ROWS  = 30
) (
    input  logic                 clk_50,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 pause,
    input  logic                 gen_valid,
    input  logic [7:0]           gen_ascii,
    input  logic [5:0]           gen_x,
    output logic                 gen_ready,
    input  logic                 key_valid,
    input  logic [7:0]           key_ascii,
    output logic [SLOTS-1:0]     slot_active,
    output logic [8*SLOTS-1:0]   slot_ascii,
    output logic [6*SLOTS-1:0]   slot_x,
    output logic [5*SLOTS-1:0]   slot_y,
    output logic [3:0]           hit_h,
    output logic [3:0]           hit_l,
    output logic [3:0]           miss_h,
    output logic [3:0]           miss_l,
    output logic                 hit_pulse,
    output logic                 miss_pulse
);

    localparam logic [4:0] BOTTOM_ROW = 5'(ROWS - 1);

    logic [SLOTS-1:0] active_q;
    logic [7:0]       ascii_q [SLOTS];
    logic [5:0]       x_q     [SLOTS];
    logic [4:0]       y_q     [SLOTS];

    logic [7:0]       key_folded;
    logic             key_is_letter;
    logic             key_go;
    logic             tick_go;
    logic [SLOTS-1:0] win_oh;
    logic [4:0]       best_y;
    logic             win_found;
    logic             hit_now;
    logic [SLOTS-1:0] free_oh;
    logic             any_free;
    logic             accept;
    logic [SLOTS-1:0] expire;
    logic [3:0]       miss_count;
    logic [7:0]       hit_next;
    logic [7:0]       miss_next;

    // Adds a small increment (0..9) to a two-digit BCD value. The units digit
    // can carry at most once, and the tens digit wraps 9 -> 0 so the counter
    // runs modulo 100.
    function automatic logic [7:0] bcd_add(input logic [3:0] tens,
                                           input logic [3:0] units,
                                           input logic [3:0] inc);
        logic [4:0] sum;
        logic [3:0] tens_out;
        sum      = {1'b0, units} + {1'b0, inc};
        tens_out = tens;
        if (sum >= 5'd10) begin
            sum      = sum - 5'd10;
            tens_out = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end
        return {tens_out, sum[3:0]};
    endfunction

    // Fold lower-case key codes onto upper case and flag real letters; any
    // other code is treated as no key at all.
    always_comb begin
        key_folded = key_ascii;
        if (key_ascii >= 8'h61 && key_ascii <= 8'h7A) begin
            key_folded = key_ascii - 8'h20;
        end
        key_is_letter = (key_folded >= 8'h41) && (key_folded <= 8'h5A);
        key_go        = key_valid && !pause && key_is_letter;
        tick_go       = tick && !pause;
    end

    // Pick the matching slot closest to the bottom. The strict greater-than
    // keeps the lowest index when two candidates share a row.
    always_comb begin
        win_oh    = '0;
        best_y    = '0;
        win_found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (key_go && active_q[i] && ascii_q[i] == key_folded &&
                (!win_found || y_q[i] > best_y)) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                best_y    = y_q[i];
                win_found = 1'b1;
            end
        end
        hit_now = win_found;
    end

    // Lowest-index free slot from registered occupancy only, so a slot freed
    // this cycle is not reused until the next one.
    always_comb begin
        free_oh  = '0;
        any_free = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!active_q[i] && !any_free) begin
                free_oh[i] = 1'b1;
                any_free   = 1'b1;
            end
        end
        gen_ready = any_free && !pause;
        accept    = gen_valid && gen_ready;
    end

    // Letters sitting on the bottom row expire on a tick, unless the same
    // cycle's key claims them as a hit. Count them for a single BCD add.
    always_comb begin
        expire     = '0;
        miss_count = '0;
        for (int i = 0; i < SLOTS; i++) begin
            expire[i]  = tick_go && active_q[i] && (y_q[i] == BOTTOM_ROW) && !win_oh[i];
            miss_count = miss_count + {3'b000, expire[i]};
        end
        hit_next  = bcd_add(hit_h, hit_l, 4'd1);
        miss_next = bcd_add(miss_h, miss_l, miss_count);
    end

    // Slot storage. A newly accepted slot was free before the edge, so its
    // load never competes with a hit, an expiry or a fall on the same slot.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            active_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                ascii_q[i] <= '0;
                x_q[i]     <= '0;
                y_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < SLOTS; i++) begin
                if (accept && free_oh[i]) begin
                    active_q[i] <= 1'b1;
                    ascii_q[i]  <= gen_ascii;
                    x_q[i]      <= gen_x;
                    y_q[i]      <= '0;
                end else if (win_oh[i] || expire[i]) begin
                    active_q[i] <= 1'b0;
                    y_q[i]      <= '0;
                end else if (tick_go && active_q[i]) begin
                    y_q[i] <= y_q[i] + 5'd1;
                end
            end
        end
    end

    // Score counters and the one-cycle event strobes.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            hit_h      <= '0;
            hit_l      <= '0;
            miss_h     <= '0;
            miss_l     <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            if (hit_now) begin
                {hit_h, hit_l} <= hit_next;
            end
            if (miss_count != 4'd0) begin
                {miss_h, miss_l} <= miss_next;
            end
            hit_pulse  <= hit_now;
            miss_pulse <= (miss_count != 4'd0);
        end
    end

    assign slot_active = active_q;

    for (genvar g = 0; g < SLOTS; g++) begin : g_out
        assign slot_ascii[8*g +: 8] = ascii_q[g];
        assign slot_x[6*g +: 6]     = x_q[g];
        assign slot_y[5*g +: 5]     = y_q[g];
    end

endmodule

// File: doc/typing_judge.md
# typing_judge

Game-logic back end for the letter-typing game. It consumes the random letter/column stream from the game's random generator and the decoded key stream from the keyboard front end. It keeps up to SLOTS falling letters, advances them one row per game tick, clears a letter when its key is typed, and keeps BCD hit/miss scores for the seven-segment display and VGA renderer.

## Interface
- SLOTS, 4: number of simultaneously falling letters (1..8)
- ROWS, 30: screen rows; row ROWS-1 is the bottom row
- clk_50  in  1  system clock, 50 MHz, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-cycle pulse per fall step, from the game timebase
- pause  in  1  level; freezes falling, matching and acceptance
- gen_valid  in  1  one-cycle pulse; new letter offered by the generator
- gen_ascii  in  8  offered letter, 0x41..0x5A
- gen_x  in  6  offered column, 0..63, stored unmodified
- gen_ready  out  1  combinational: (any slot free) && !pause
- key_valid  in  1  one-cycle pulse; key released/decoded
- key_ascii  in  8  key code; 0x61..0x7A folded to 0x41..0x5A; all other non-letter codes ignored
- slot_active  out  SLOTS  per-slot occupied flag
- slot_ascii  out  8*SLOTS  slot i at [8i+7:8i]
- slot_x  out  6*SLOTS  slot i at [6i+5:6i]
- slot_y  out  5*SLOTS  slot i at [5i+4:5i], row 0 = top
- hit_h, hit_l  out  4 each  BCD hit count, tens/units
- miss_h, miss_l  out  4 each  BCD miss count, tens/units
- hit_pulse, miss_pulse  out  1 each  one-cycle event strobes

## Operation
- Reset: all slot_active=0, slot_ascii=0, slot_x=0, slot_y=0, all BCD digits=0, hit_pulse=miss_pulse=0. gen_ready=1 when pause=0.
- Accept: gen_valid && gen_ready loads the lowest-index free slot with ascii=gen_ascii, x=gen_x, y=0, active=1. If gen_valid is high while gen_ready is low, the offer is dropped and no state changes.
- Fall: tick && !pause increments y of every slot that was active at the start of the cycle. A slot with y==ROWS-1 does not increment; it is freed (active=0, y=0) and counts as one miss.
- Match: key_valid && !pause with a folded letter compares against the active slots that held that letter at the start of the cycle. The winning slot is the one with the greatest y; ties go to the lowest index. The winner is freed, hit increments by 1, and exactly one slot is cleared per key. No match: nothing happens and there is no penalty.
- Simultaneous events in one cycle are all evaluated against the pre-edge state:
  - key match and tick: the matched slot is freed as a hit, never as a miss, even if it sits at ROWS-1; other slots still fall.
  - accept and tick: the new slot is written with y=0 and does not fall in this cycle.
  - accept and free: a slot freed in this cycle cannot be reused until the next cycle, because gen_ready and the free-slot choice use pre-edge occupancy.
- Miss arithmetic: k slots expiring in one tick (0..SLOTS) add k to the miss count in a single BCD add with carry.
- Counters: both counters are two-digit BCD, 00..99, and wrap 99 -> 00 modulo 100 (e.g. 98 + 3 = 01).
- Pause: tick and key_valid are ignored, gen_ready=0, and all slot state and counts hold.
- rst has priority over every other input in the same cycle.

## Timing
- Single clock domain; all inputs are synchronous to clk_50.
- Latency is 1 cycle. Slot state, counters and pulses update on the edge that samples the event.
- hit_pulse is high for exactly the cycle after a matching key. miss_pulse is high for exactly the cycle after a tick with k>=1, and is a single pulse regardless of k.
- gen_ready is combinational from registered occupancy and pause, with no dependence on same-cycle inputs.
- Back-to-back events on consecutive cycles are all honored; the block never stalls.

## Test plan
- Reset, then gen_valid with 0x4B ('K'), x=12 -> slot0 active, ascii=0x4B, x=12, y=0; gen_ready=1; counts 00/00.
- Fill 4 slots, then offer a fifth -> gen_ready=0 and the fifth is dropped. Apply key 0x6B ('k') while slot2 holds 'K' -> slot2 freed, hit=01, hit_pulse for 1 cycle, gen_ready=1.
- Slots 0 and 3 both hold 'A', with y=7 and y=9 -> key 'A' clears slot3 only; a second 'A' clears slot0; a third 'A' changes nothing.
- Two slots at y=29 and one tick -> both freed, miss goes 00->02, one miss_pulse. The same setup with key matching one slot in the tick cycle -> hit+1, miss+1.
- Preload miss=98 and expire 3 slots in one tick -> miss=01. Preload hit=99 and hit once -> 00.
- pause=1 with tick, key and gen_valid all pulsed -> no change, gen_ready=0. Assert rst mid-fall -> all outputs return to their reset values on the next edge.
